// File: rtl/logic_unit.sv
// logic_unit: pipelined eight-op bitwise unit with elastic valid/ready stages.
// Optional zero flag (port z and per-stage zero bits) is enabled by defining LOGIC_UNIT_ZERO_FLAG_EN.
module logic_unit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    output logic             z,
`endif
    output logic [0:WIDTH-1] y
);
    logic [0:WIDTH-1]  res;
    logic [STAGES-1:0] v_q, v_d, rdy;
    logic [0:WIDTH-1]  d_q [STAGES];
    logic [0:WIDTH-1]  d_d [STAGES];
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    logic [STAGES-1:0] z_q, z_d;
`endif

    // Selected logical operation on the incoming operands.
    always_comb begin
        case (op)
            3'b000:  res = a & b;
            3'b001:  res = a | b;
            3'b010:  res = a ^ b;
            3'b011:  res = a & ~b;
            3'b100:  res = a | ~b;
            3'b101:  res = ~(a & b);
            3'b110:  res = ~(a | b);
            default: res = ~(a ^ b);
        endcase
    end

    // A stage can take a beat unless it and every later stage are full while the output stalls.
    always_comb begin
        for (int i = 0; i < STAGES; i++)
            rdy[i] = out_ready || !(&(v_q | STAGES'((1 << i) - 1)));
    end

    // Advance every stage that can take a beat; a stage with no incoming beat empties and clears.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        z_d = z_q;
`endif
        if (rdy[0]) begin
            v_d[0] = in_valid;
            d_d[0] = in_valid ? res : '0;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
            z_d[0] = in_valid && (res == '0);
`endif
        end
        for (int i = 1; i < STAGES; i++) begin
            if (rdy[i]) begin
                v_d[i] = v_q[i-1];
                d_d[i] = v_q[i-1] ? d_q[i-1] : '0;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
                z_d[i] = v_q[i-1] && z_q[i-1];
`endif
            end
        end
    end

    // Pipeline registers; reset discards every in-flight beat immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < STAGES; i++)
                d_q[i] <= '0;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
            z_q <= '0;
`endif
        end else begin
            v_q <= v_d;
            d_q <= d_d;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
            z_q <= z_d;
`endif
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign y         = d_q[STAGES-1];
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    assign z         = z_q[STAGES-1];
`endif

endmodule
